// File: rtl/uinst_sequencer.sv
// uinst_sequencer: micro-sequencer / fetch stage ahead of the micro-instruction pipeline register.
//
// Holds the micro-PC, addresses a registered control-store ROM, splits the returned
// micro-word into fields and presents them with a load enable (EN) to the pipeline
// register. The next micro-address is selected from the M/T fields and FLAG. A
// one-cycle bubble is inserted when the word reads the register written by the
// previously issued word. An external stall freezes issue.
//
// Ports:
//   CLK, nRESET        clock (rising edge), asynchronous active-low reset
//   START              begin execution at RESET_UPC (honoured only in IDLE or HALT)
//   STALL              freeze issue while in ISSUE
//   FLAG               branch condition for M=10, sampled in the ISSUE cycle
//   CS_ADDR / CS_DATA  control-store address (= uPC) and word (valid one cycle later)
//   busA/B/C_out, ALUC_out, SH_out, KMx_out, T_out, M_out   fields to pipeline register
//   EN                 pipeline register load enable
//   HALTED             high while halted

module uinst_sequencer #(
    parameter int unsigned      UPC_W     = 7,
    parameter logic [UPC_W-1:0] RESET_UPC = '0,
    parameter logic [5:0]       NOREG     = 6'b111111
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                START,
    input  logic                STALL,
    input  logic                FLAG,
    output logic [UPC_W-1:0]    CS_ADDR,
    input  logic [UPC_W+26:0]   CS_DATA,
    output logic [5:0]          busA_out,
    output logic [5:0]          busB_out,
    output logic [5:0]          busC_out,
    output logic [3:0]          ALUC_out,
    output logic [1:0]          SH_out,
    output logic                KMx_out,
    output logic [UPC_W-1:0]    T_out,
    output logic [1:0]          M_out,
    output logic                EN,
    output logic                HALTED
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic [5:0]       last_busc_q, last_busc_d;

    // Micro-word field decode; T width tracks UPC_W, everything above it shifts with it.
    logic [5:0]       f_busa, f_busb, f_busc;
    logic [3:0]       f_aluc;
    logic [1:0]       f_sh;
    logic             f_kmx;
    logic [UPC_W-1:0] f_t;
    logic [1:0]       f_m;

    assign f_m    = CS_DATA[1:0];
    assign f_t    = CS_DATA[UPC_W+1:2];
    assign f_kmx  = CS_DATA[UPC_W+2];
    assign f_sh   = CS_DATA[UPC_W+4:UPC_W+3];
    assign f_aluc = CS_DATA[UPC_W+8:UPC_W+5];
    assign f_busc = CS_DATA[UPC_W+14:UPC_W+9];
    assign f_busb = CS_DATA[UPC_W+20:UPC_W+15];
    assign f_busa = CS_DATA[UPC_W+26:UPC_W+21];

    logic             hazard;
    logic [UPC_W-1:0] upc_inc;

    // RAW: current word reads the register the previous live issue writes.
    assign hazard  = (last_busc_q != NOREG) && ((f_busa == last_busc_q) || (f_busb == last_busc_q));
    assign upc_inc = upc_q + UPC_W'(1);

    assign CS_ADDR = upc_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= StIdle;
            upc_q       <= RESET_UPC;
            last_busc_q <= NOREG;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            last_busc_q <= last_busc_d;
        end
    end

    // Outputs are decoded from the registered state, so an asynchronous reset forces
    // EN low and bubble fields without waiting for a clock edge.
    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        last_busc_d = last_busc_q;
        EN          = 1'b0;
        HALTED      = 1'b0;
        busA_out    = NOREG;
        busB_out    = NOREG;
        busC_out    = NOREG;
        ALUC_out    = 4'd0;
        SH_out      = 2'd0;
        KMx_out     = 1'b0;
        T_out       = '0;
        M_out       = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d     = StFetch;
                    upc_d       = RESET_UPC;
                    last_busc_d = NOREG;
                end
            end

            StFetch: begin
                state_d = StIssue;
            end

            StIssue: begin
                if (!STALL) begin
                    EN = 1'b1;
                    if (hazard) begin
                        // Bubble: uPC held so the same word is re-presented next cycle.
                        last_busc_d = NOREG;
                    end else begin
                        busA_out    = f_busa;
                        busB_out    = f_busb;
                        busC_out    = f_busc;
                        ALUC_out    = f_aluc;
                        SH_out      = f_sh;
                        KMx_out     = f_kmx;
                        T_out       = f_t;
                        M_out       = f_m;
                        last_busc_d = f_busc;
                        state_d     = StFetch;
                        unique case (f_m)
                            2'b00: upc_d = upc_inc;
                            2'b01: upc_d = f_t;
                            2'b10: upc_d = FLAG ? f_t : upc_inc;
                            2'b11: state_d = StHalt;
                            default: state_d = StHalt;
                        endcase
                    end
                end
            end

            StHalt: begin
                HALTED = 1'b1;
                if (START) begin
                    state_d     = StFetch;
                    upc_d       = RESET_UPC;
                    last_busc_d = NOREG;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_uinst_sequencer.sv
// Self-checking bench for uinst_sequencer: a per-cycle directed table, a hand-written
// asynchronous-reset sequence, and randomized stimulus against a behavioural model.
module tb_uinst_sequencer;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        START = 1'b0;
    logic        STALL = 1'b0;
    logic        FLAG = 1'b0;
    logic [6:0]  CS_ADDR;
    logic [33:0] CS_DATA = '0;
    logic [5:0]  busA_out, busB_out, busC_out;
    logic [3:0]  ALUC_out;
    logic [1:0]  SH_out;
    logic        KMx_out;
    logic [6:0]  T_out;
    logic [1:0]  M_out;
    logic        EN, HALTED;

    int checks = 0;
    int failures = 0;

    uinst_sequencer dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .START    (START),
        .STALL    (STALL),
        .FLAG     (FLAG),
        .CS_ADDR  (CS_ADDR),
        .CS_DATA  (CS_DATA),
        .busA_out (busA_out),
        .busB_out (busB_out),
        .busC_out (busC_out),
        .ALUC_out (ALUC_out),
        .SH_out   (SH_out),
        .KMx_out  (KMx_out),
        .T_out    (T_out),
        .M_out    (M_out),
        .EN       (EN),
        .HALTED   (HALTED)
    );

    always #5 CLK = ~CLK;

    // Registered control-store ROM.
    logic [33:0] rom [128];
    always @(posedge CLK) CS_DATA <= rom[CS_ADDR];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [33:0] mkw(int a, int b, int c, int t, int m);
        return {6'(a), 6'(b), 6'(c), 4'd0, 2'd0, 1'b0, 7'(t), 2'(m)};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Directed per-cycle table.
    typedef struct {
        bit       start, stall, flag;
        bit       e_en;
        bit [6:0] e_addr;
        bit [5:0] e_a, e_b, e_c;
        bit       e_halted;
    } vec_t;

    function automatic vec_t mkv(bit st, bit sl, bit fl, bit en, int addr, int a, int b, int c,
                                 bit h);
        vec_t v;
        v.start = st; v.stall = sl; v.flag = fl; v.e_en = en; v.e_addr = 7'(addr);
        v.e_a = 6'(a); v.e_b = 6'(b); v.e_c = 6'(c); v.e_halted = h;
        return v;
    endfunction

    // Behavioural model: spec states as plain ints, word decoded straight from rom[uPC].
    int m_mode;  // 0 idle, 1 fetch, 2 issue, 3 halt
    int m_upc;
    int m_last;

    task automatic model_cycle(input bit rst, input bit start, input bit stall, input bit flag,
                               output logic [42:0] e);
        logic [33:0] w;
        logic        en, halted;
        logic [5:0]  a, b, c;
        logic [3:0]  al;
        logic [1:0]  sh, m;
        logic        km;
        logic [6:0]  t;
        en = 1'b0; a = 6'd63; b = 6'd63; c = 6'd63; al = '0; sh = '0; km = 1'b0; t = '0;
        m = '0;
        if (rst) begin
            m_mode = 0; m_upc = 0; m_last = 63;
            e = {1'b0, 1'b0, 7'd0, a, b, c, al, sh, km, t, m};
            return;
        end
        halted = (m_mode == 3);
        e = '0;
        e[40:34] = 7'(m_upc);
        case (m_mode)
            0, 3: if (start) begin m_mode = 1; m_upc = 0; m_last = 63; end
            1: m_mode = 2;
            default: begin
                if (!stall) begin
                    w = rom[m_upc];
                    en = 1'b1;
                    if (m_last != 63 && (int'(w[33:28]) == m_last || int'(w[27:22]) == m_last))
                    begin
                        m_last = 63;
                    end else begin
                        a = w[33:28]; b = w[27:22]; c = w[21:16]; al = w[15:12];
                        sh = w[11:10]; km = w[9]; t = w[8:2]; m = w[1:0];
                        m_last = int'(c);
                        m_mode = 1;
                        case (int'(m))
                            0: m_upc = (m_upc + 1) % 128;
                            1: m_upc = int'(t);
                            2: m_upc = flag ? int'(t) : (m_upc + 1) % 128;
                            default: m_mode = 3;
                        endcase
                    end
                end
            end
        endcase
        e = {en, halted, e[40:34], a, b, c, al, sh, km, t, m};
    endtask

    vec_t tbl [27];

    initial begin
        logic [42:0] got, exp;
        bit rst, st, sl, fl;

        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0]   = mkw(1, 2, 3, 0, 0);
        rom[1]   = mkw(3, 4, 5, 7'h40, 2);
        rom[2]   = mkw(40, 41, 42, 0, 3);
        rom[7'h40] = mkw(10, 11, 12, 7'h20, 0);
        rom[7'h41] = mkw(20, 21, 22, 127, 1);
        rom[127] = mkw(30, 31, 32, 0, 0);

        //               st sl fl en addr  a   b   c  halted
        tbl[0]  = mkv(1, 0, 0, 0, 0,    63, 63, 63, 0);  // idle, START
        tbl[1]  = mkv(0, 0, 0, 0, 0,    63, 63, 63, 0);  // fetch
        tbl[2]  = mkv(0, 0, 0, 1, 0,    1,  2,  3,  0);  // live rom[0]
        tbl[3]  = mkv(0, 0, 0, 0, 1,    63, 63, 63, 0);
        tbl[4]  = mkv(0, 0, 1, 1, 1,    63, 63, 63, 0);  // hazard bubble
        tbl[5]  = mkv(0, 0, 1, 1, 1,    3,  4,  5,  0);  // live, FLAG=1 -> 0x40
        tbl[6]  = mkv(0, 0, 0, 0, 'h40, 63, 63, 63, 0);
        tbl[7]  = mkv(0, 0, 0, 1, 'h40, 10, 11, 12, 0);
        tbl[8]  = mkv(0, 0, 0, 0, 'h41, 63, 63, 63, 0);
        tbl[9]  = mkv(0, 1, 0, 0, 'h41, 63, 63, 63, 0);  // stalled
        tbl[10] = mkv(0, 1, 0, 0, 'h41, 63, 63, 63, 0);
        tbl[11] = mkv(0, 1, 0, 0, 'h41, 63, 63, 63, 0);
        tbl[12] = mkv(0, 0, 0, 1, 'h41, 20, 21, 22, 0);  // released: jump to 127
        tbl[13] = mkv(0, 1, 0, 0, 127,  63, 63, 63, 0);  // stall in fetch ignored
        tbl[14] = mkv(0, 0, 0, 1, 127,  30, 31, 32, 0);  // wrap to 0
        tbl[15] = mkv(1, 0, 0, 0, 0,    63, 63, 63, 0);  // START ignored in fetch
        tbl[16] = mkv(1, 0, 0, 1, 0,    1,  2,  3,  0);  // START ignored in issue
        tbl[17] = mkv(0, 0, 0, 0, 1,    63, 63, 63, 0);
        tbl[18] = mkv(0, 0, 0, 1, 1,    63, 63, 63, 0);  // bubble again
        tbl[19] = mkv(0, 0, 0, 1, 1,    3,  4,  5,  0);  // FLAG=0 -> 2
        tbl[20] = mkv(0, 0, 0, 0, 2,    63, 63, 63, 0);
        tbl[21] = mkv(0, 0, 0, 1, 2,    40, 41, 42, 0);  // M=11
        tbl[22] = mkv(0, 0, 0, 0, 2,    63, 63, 63, 1);  // halted
        tbl[23] = mkv(0, 1, 0, 0, 2,    63, 63, 63, 1);
        tbl[24] = mkv(1, 0, 0, 0, 2,    63, 63, 63, 1);  // restart
        tbl[25] = mkv(0, 0, 0, 0, 0,    63, 63, 63, 0);
        tbl[26] = mkv(0, 0, 0, 1, 0,    1,  2,  3,  0);

        // Reset state
        nRESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'({EN, HALTED, CS_ADDR, busA_out, busB_out, busC_out, ALUC_out,
                                  SH_out, KMx_out, T_out, M_out}),
            64'({1'b0, 1'b0, 7'd0, 6'd63, 6'd63, 6'd63, 4'd0, 2'd0, 1'b0, 7'd0, 2'd0}));
        nRESET = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            START = tbl[i].start; STALL = tbl[i].stall; FLAG = tbl[i].flag;
            #1;
            chk($sformatf("vec[%0d]", i),
                64'({EN, HALTED, CS_ADDR, busA_out, busB_out, busC_out}),
                64'({tbl[i].e_en, tbl[i].e_halted, tbl[i].e_addr, tbl[i].e_a, tbl[i].e_b,
                     tbl[i].e_c}));
            tick();
        end
        START = 1'b0; STALL = 1'b0; FLAG = 1'b0;

        // Asynchronous reset in the middle of an ISSUE cycle (hazard on rom[1]).
        #1;
        chk("pre_reset_fetch", 64'({EN, CS_ADDR}), 64'({1'b0, 7'd1}));
        tick();
        #1;
        chk("pre_reset_issue", 64'(EN), 64'(1'b1));
        nRESET = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({EN, HALTED, CS_ADDR, busA_out, busB_out, busC_out,
                                        ALUC_out, T_out, M_out}),
            64'({1'b0, 1'b0, 7'd0, 6'd63, 6'd63, 6'd63, 4'd0, 7'd0, 2'd0}));
        tick();
        nRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("idle_after_reset[%0d]", i), 64'({EN, HALTED, CS_ADDR}), 64'(0));
            tick();
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        #1;
        chk("resume_issue", 64'({EN, CS_ADDR, busA_out, busC_out}),
            64'({1'b1, 7'd0, 6'd1, 6'd3}));
        tick();

        // Randomized stimulus against the model.
        for (int i = 0; i < 128; i++) begin
            logic [5:0] r [3];
            for (int k = 0; k < 3; k++) begin
                int v;
                v = int'($urandom_range(0, 8));
                r[k] = (v == 8) ? 6'd63 : 6'(v);
            end
            begin
                int mv;
                logic [1:0] m;
                mv = int'($urandom_range(0, 9));
                m = (mv < 4) ? 2'd0 : (mv < 6) ? 2'd1 : (mv < 9) ? 2'd2 : 2'd3;
                rom[i] = {r[0], r[1], r[2], 4'($urandom), 2'($urandom), 1'($urandom),
                          7'($urandom), m};
            end
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            fl  = 1'($urandom);
            nRESET = !rst; START = st; STALL = sl; FLAG = fl;
            #1;
            got = {EN, HALTED, CS_ADDR, busA_out, busB_out, busC_out, ALUC_out, SH_out, KMx_out,
                   T_out, M_out};
            model_cycle(rst, st, sl, fl, exp);
            chk($sformatf("random[%0d]", cyc), 64'(got), 64'(exp));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uinst_sequencer.md
Name: uinst_sequencer

Overview:
- Micro-sequencer and fetch stage directly upstream of the micro-instruction pipeline register.
- Holds the micro-PC and addresses the registered control-store ROM.
- Splits each 34-bit micro-word into busA/busB/busC/ALUC/SH/KMx/T/M fields and drives them, with EN, into the pipeline register.
- Computes the next micro-address from M/T/FLAG, inserts a one-cycle bubble on register RAW hazards, and freezes on external stall.

Parameters:
- UPC_W, 7, micro-PC and control-store address width; equals T field width.
- RESET_UPC, 7'd0, micro-address loaded at reset and on START.
- NOREG, 6'b111111, bus code meaning "no register".

Ports:
- CLK  in  1  system clock, rising edge.
- nRESET  in  1  asynchronous active-low reset.
- START  in  1  begin execution at RESET_UPC; honoured only in IDLE or HALT.
- STALL  in  1  external stall; freezes issue.
- FLAG  in  1  branch condition, sampled in the ISSUE cycle.
- CS_ADDR  out  UPC_W  control-store address (= uPC).
- CS_DATA  in  34  control-store word; valid the cycle after CS_ADDR. Packing: busA[33:28] busB[27:22] busC[21:16] ALUC[15:12] SH[11:10] KMx[9] T[8:2] M[1:0].
- busA_out, busB_out, busC_out  out  6 each  register selects to the pipeline register.
- ALUC_out  out  4;  SH_out  out  2;  KMx_out  out  1;  T_out  out  7;  M_out  out  2.
- EN  out  1  load enable for the pipeline register.
- HALTED  out  1  high in HALT state.

Behaviour:
- Reset (async, nRESET=0): state IDLE; uPC=RESET_UPC; last_busC=NOREG; EN=0; HALTED=0.
- Bubble values on all field outputs: busA/B/C=NOREG, ALUC=0, SH=0, KMx=0, T=0, M=0.
- Field outputs carry bubble values in every cycle except a live issue.
- States: IDLE, FETCH, ISSUE, HALT.
  - IDLE: EN=0. START -> FETCH with uPC=RESET_UPC.
  - FETCH: CS_ADDR=uPC, EN=0. Always -> ISSUE next cycle; CS_DATA is then valid.
  - ISSUE, STALL=1: EN=0, stay in ISSUE. uPC and last_busC unchanged; hazard not evaluated.
  - ISSUE, STALL=0, hazard: EN=1 with bubble fields; last_busC<=NOREG; stay in ISSUE. CS_ADDR is unchanged, so the word is re-presented next cycle. Hazard means last_busC!=NOREG and (busA==last_busC or busB==last_busC).
  - ISSUE, STALL=0, no hazard (live issue): EN=1, fields = CS_DATA fields, last_busC<=busC field. Next uPC by M:
    - 00: uPC+1, mod 2^UPC_W; 127 wraps to 0.
    - 01: T.
    - 10: T if FLAG=1, else uPC+1.
    - 11: uPC unchanged, state -> HALT.
    - For M=00/01/10, state -> FETCH.
- Throughput: at most one live issue per 2 cycles; a hazard adds 1 cycle and each stall cycle adds 1.
- Latency: START asserted at edge n -> first EN=1 during cycle n+2, assuming no stall.
- HALT: EN=0, HALTED=1. START -> FETCH at RESET_UPC, last_busC<=NOREG, HALTED=0 next cycle.
- START is ignored in FETCH and ISSUE.
- STALL in FETCH/IDLE/HALT has no effect.
- Reset mid-ISSUE: outputs drop to reset values immediately, without waiting for a clock edge. The pipeline register sees no EN pulse.

Test Plan:
- Reset then START, ROM[0]=busA 1, busB 2, busC 3, M=00 -> CS_ADDR=0, EN=1 one cycle with busA_out=1 busC_out=3; next CS_ADDR=1.
- ROM[1] has busA=3 (reads the busC just written) -> one bubble cycle (EN=1, all bus outs 63), then live issue of ROM[1]. Total 3 cycles from FETCH.
- M=10, T=0x40: FLAG=1 -> next CS_ADDR=0x40; repeat with FLAG=0 -> next CS_ADDR=uPC+1.
- STALL=1 for 3 cycles during ISSUE -> EN=0 throughout, CS_ADDR constant, fields not issued. Released -> single issue, no duplicate.
- uPC=127 with M=00 -> next CS_ADDR=0. M=11 -> issued once, then HALTED=1, EN=0. START -> CS_ADDR=0, HALTED=0.
- nRESET pulsed low mid-ISSUE -> EN=0 and bubble fields immediately; state IDLE; START required to resume.
